// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) arbiter onto one shared memory bus; data has fixed priority.
// Optional bus-wait timeout is built when ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,

    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,

    input  logic              flush,

    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ready,

    output logic              stall_if,
    output logic              stall_mem,
    output logic              bus_err
);

    // state    | meaning
    // IDLE     | no bus cycle; arbitrate, data before fetch
    // IF_BUSY  | fetch cycle on the bus
    // MEM_BUSY | load/store cycle on the bus (immune to flush)
    // DRAIN    | flushed fetch still on the bus; finish it silently
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] IF_BUSY  = 2'd1;
    localparam logic [1:0] MEM_BUSY = 2'd2;
    localparam logic [1:0] DRAIN    = 2'd3;

    logic [1:0] state;
    logic       grant_mem;
    logic       grant_if;
    logic       expire;

    // A request seen together with its own ack is the one just completed, not a new one.
    assign grant_mem = mem_req & ~mem_ack;
    assign grant_if  = if_req & ~if_ack & ~flush;

    assign bus_req   = (state != IDLE);
    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = mem_req & ~mem_ack;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] wait_cnt;

    assign expire = (state != IDLE) && !bus_ready && (wait_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 8'd0;
            bus_err  <= 1'b0;
        end else begin
            bus_err <= expire;
            if (state == IDLE || (state == IF_BUSY && flush))
                wait_cnt <= 8'd0;
            else if (!bus_ready)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end
`else
    assign expire  = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            if_ack    <= 1'b0;
            mem_ack   <= 1'b0;
        end else begin
            if_ack  <= 1'b0;
            mem_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_mem) begin
                        bus_we    <= mem_we;
                        bus_addr  <= mem_addr;
                        bus_wdata <= mem_wdata;
                        state     <= MEM_BUSY;
                    end else if (grant_if) begin
                        bus_we    <= 1'b0;
                        bus_addr  <= if_addr;
                        state     <= IF_BUSY;
                    end
                end
                IF_BUSY: begin
                    if (bus_ready) begin
                        if (!flush) begin
                            if_rdata <= bus_rdata;
                            if_ack   <= 1'b1;
                        end
                        state <= IDLE;
                    end else if (expire) begin
                        if (!flush) begin
                            if_rdata <= '0;
                            if_ack   <= 1'b1;
                        end
                        state <= IDLE;
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                MEM_BUSY: begin
                    if (bus_ready) begin
                        if (!bus_we)
                            mem_rdata <= bus_rdata;
                        mem_ack <= 1'b1;
                        state   <= IDLE;
                    end else if (expire) begin
                        mem_rdata <= '0;
                        mem_ack   <= 1'b1;
                        state     <= IDLE;
                    end
                end
                DRAIN: begin
                    if (bus_ready || expire)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
